traffic_light_multi: RTL and testbench
======================================

TRAFFIC_LIGHT_MULTI -- requirements
Module: traffic_light_multi

Interface
REQ-001 Parameters SHALL be:
- NUM_DIR, 4: number of approaches, legal 2..8.
- TICK_DIV, 1000: clk cycles per timing tick, legal >=1.
- GREEN_TICKS, 30: base green duration in ticks, legal >=1.
- YELLOW_TICKS, 5: yellow duration in ticks, legal >=1.
- ALLRED_TICKS, 2: all-red clearance in ticks, legal >=1.
- PED_EXTRA, 10: green extension in ticks when a pedestrian call is served, legal >=0.
- CNT_W, 16: tick and phase counter width; must hold every duration.
REQ-002 Ports SHALL be:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- en, input, 1: run enable; low freezes all timing.
- flash_mode, input, 1: request for the flashing-yellow maintenance mode.
- ped_req, input, NUM_DIR: pedestrian call per approach, 1-cycle pulse or level.
- lights, output, 3*NUM_DIR: per approach i, bits [3i+2:3i] = {red, yellow, green}, one-hot except in FLASH.
- walk, output, NUM_DIR: walk indication per approach.
- active_dir, output, 3: index of the approach that currently owns or last owned green.
- in_flash, output, 1: high while the state is FLASH.

Function
REQ-003 All outputs SHALL be registered and SHALL change only on rising edges of clk or on rst assertion.
REQ-004 Prescaler SHALL count 0..TICK_DIV-1 while en=1; tick SHALL be an internal 1-cycle pulse on the count TICK_DIV-1.
REQ-005 With en=0, the prescaler, phase counter, state and outputs SHALL hold; ped_req latching SHALL continue.
REQ-006 FSM states SHALL be ALL_RED, GREEN, YELLOW and FLASH; each timed state SHALL last exactly its duration in ticks.
REQ-007 A phase transition SHALL occur on the edge where tick=1 and the phase count equals duration-1; the phase count SHALL then return to 0.
REQ-008 The normal sequence SHALL be:
- ALL_RED -> GREEN(active_dir) -> YELLOW -> ALL_RED.
- On YELLOW->ALL_RED, active_dir SHALL advance to (active_dir+1) mod NUM_DIR, wrapping from NUM_DIR-1 to 0.
REQ-009 Exactly one approach SHALL be non-red outside FLASH; every other approach SHALL show red.
REQ-010 ped_req[i] SHALL set a sticky latch ped_pend[i]; the latch SHALL clear only on entry to GREEN for approach i.
REQ-011 On GREEN entry with ped_pend[active_dir]=1:
- Green duration SHALL be GREEN_TICKS+PED_EXTRA.
- walk[active_dir] SHALL be high for the whole green, and low in YELLOW.
REQ-012 A ped_req for the approach currently in GREEN SHALL be held for that approach's next green.
REQ-013 A ped_req arriving on the same edge as its own GREEN entry SHALL be served by that green.
REQ-014 flash_mode=1 sampled during GREEN SHALL truncate green: next edge enters YELLOW with the phase count cleared, regardless of tick.
REQ-015 flash_mode=1 during YELLOW or ALL_RED SHALL let the phase complete; the transition out of ALL_RED SHALL then go to FLASH instead of GREEN.
REQ-016 In FLASH:
- Green and red bits SHALL be low on all approaches.
- Yellow on all approaches SHALL toggle on every tick, starting high.
- walk SHALL be all 0 and in_flash SHALL be 1.
REQ-017 Leaving FLASH on flash_mode=0 SHALL take effect at the next tick and enter ALL_RED; active_dir SHALL be left unchanged.
REQ-018 Green SHALL never follow green or FLASH directly; every green SHALL be preceded by at least ALLRED_TICKS of ALL_RED.

Reset
REQ-019 While rst=0, the following SHALL hold asynchronously:
- State = ALL_RED; prescaler, phase count and ped_pend cleared.
- active_dir = 0, lights = all red (bit 3i+2 set), walk = 0, in_flash = 0.
REQ-020 Reset asserted mid-phase SHALL abort the phase immediately; after release, the first tick SHALL occur TICK_DIV cycles later.

Verification
Parameters for all scenarios: NUM_DIR=3, TICK_DIV=4, GREEN_TICKS=5, YELLOW_TICKS=2, ALLRED_TICKS=1, PED_EXTRA=3.
REQ-021 Release rst with en=1 -> 4 cycles all red; dir0 green for 20 cycles, yellow for 8, all red for 4; then dir1 green; full rotation = 96 cycles; active_dir wraps from 2 to 0.
REQ-022 Pulse ped_req[1] during dir0 green -> dir1 green lasts 32 cycles with walk[1]=1 throughout; ped_pend[1] is cleared; the next dir1 green lasts 20 cycles.
REQ-023 Assert flash_mode at cycle 10 of dir0 green -> yellow on the next edge for 8 cycles, all red for 4 cycles, then FLASH with all yellow toggling every 4 cycles and in_flash=1.
REQ-024 Deassert flash_mode in FLASH -> ALL_RED from the next tick for 4 cycles, then dir0 green (active_dir unchanged).
REQ-025 Drop en for 50 cycles mid-yellow -> all outputs frozen; yellow resumes and completes its remaining time; pulse rst low mid-green -> all red and active_dir=0 immediately.

Source files
------------

// File: rtl/traffic_light_multi.sv
// Multi-approach traffic light controller: round-robin green/yellow/all-red
// sequencing with pedestrian green extension and a flashing-yellow maintenance mode.
module traffic_light_multi #(
  parameter int NUM_DIR      = 4,
  parameter int TICK_DIV     = 1000,
  parameter int GREEN_TICKS  = 30,
  parameter int YELLOW_TICKS = 5,
  parameter int ALLRED_TICKS = 2,
  parameter int PED_EXTRA    = 10,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flash_mode,
  input  logic [NUM_DIR-1:0]     ped_req,
  output logic [3*NUM_DIR-1:0]   lights,
  output logic [NUM_DIR-1:0]     walk,
  output logic [2:0]             active_dir,
  output logic                   in_flash
);

  typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW, FLASH} state_e;

  localparam logic [3*NUM_DIR-1:0] LIGHTS_RED = {NUM_DIR{3'b100}};

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       pre_q, pre_d;
  logic [CNT_W-1:0]       ph_q, ph_d;
  logic [2:0]             dir_q, dir_d;
  logic [NUM_DIR-1:0]     pend_q, pend_d;
  logic                   pedsv_q, pedsv_d;
  logic                   fy_q, fy_d;
  logic [3*NUM_DIR-1:0]   lights_q, lights_d;
  logic [NUM_DIR-1:0]     walk_q, walk_d;
  logic                   flash_q, flash_d;

  logic                   tick;
  logic                   pend_cur;
  logic [CNT_W-1:0]       green_len;

  assign tick      = en && (pre_q == CNT_W'(TICK_DIV - 1));
  assign green_len = CNT_W'(GREEN_TICKS) + (pedsv_q ? CNT_W'(PED_EXTRA) : '0);

  // A call arriving on the green-entry edge itself must still be served.
  always_comb begin
    pend_cur = 1'b0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (dir_q == 3'(i)) pend_cur = pend_q[i] | ped_req[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    ph_d    = ph_q;
    dir_d   = dir_q;
    pend_d  = pend_q | ped_req;
    pedsv_d = pedsv_q;
    fy_d    = fy_q;
    if (en) begin
      pre_d = tick ? '0 : pre_q + CNT_W'(1);
      unique case (state_q)
        ALL_RED: begin
          if (tick && ph_q == CNT_W'(ALLRED_TICKS - 1)) begin
            ph_d = '0;
            if (flash_mode) begin
              state_d = FLASH;
              fy_d    = 1'b1;
            end else begin
              state_d = GREEN;
              pedsv_d = pend_cur;
              for (int unsigned i = 0; i < NUM_DIR; i++) begin
                if (dir_q == 3'(i)) pend_d[i] = 1'b0;
              end
            end
          end else if (tick) begin
            ph_d = ph_q + CNT_W'(1);
          end
        end
        GREEN: begin
          // Truncation also restarts the prescaler so yellow keeps its full length.
          if (flash_mode) begin
            state_d = YELLOW;
            ph_d    = '0;
            pre_d   = '0;
          end else if (tick) begin
            if (ph_q == green_len - CNT_W'(1)) begin
              state_d = YELLOW;
              ph_d    = '0;
            end else begin
              ph_d = ph_q + CNT_W'(1);
            end
          end
        end
        YELLOW: begin
          if (tick) begin
            if (ph_q == CNT_W'(YELLOW_TICKS - 1)) begin
              state_d = ALL_RED;
              ph_d    = '0;
              dir_d   = (dir_q == 3'(NUM_DIR - 1)) ? '0 : dir_q + 3'd1;
            end else begin
              ph_d = ph_q + CNT_W'(1);
            end
          end
        end
        FLASH: begin
          if (tick) begin
            if (!flash_mode) begin
              state_d = ALL_RED;
              ph_d    = '0;
            end else begin
              fy_d = ~fy_q;
            end
          end
        end
        default: state_d = ALL_RED;
      endcase
    end
  end

  always_comb begin
    lights_d = LIGHTS_RED;
    walk_d   = '0;
    flash_d  = (state_d == FLASH);
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (state_d == FLASH) begin
        lights_d[3*i +: 3] = {1'b0, fy_d, 1'b0};
      end else if (dir_d == 3'(i) && state_d == GREEN) begin
        lights_d[3*i +: 3] = 3'b001;
        walk_d[i]          = pedsv_d;
      end else if (dir_d == 3'(i) && state_d == YELLOW) begin
        lights_d[3*i +: 3] = 3'b010;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ALL_RED;
      pre_q    <= '0;
      ph_q     <= '0;
      dir_q    <= '0;
      pend_q   <= '0;
      pedsv_q  <= 1'b0;
      fy_q     <= 1'b0;
      lights_q <= LIGHTS_RED;
      walk_q   <= '0;
      flash_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      ph_q     <= ph_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      pedsv_q  <= pedsv_d;
      fy_q     <= fy_d;
      lights_q <= lights_d;
      walk_q   <= walk_d;
      flash_q  <= flash_d;
    end
  end

  assign lights     = lights_q;
  assign walk       = walk_q;
  assign active_dir = dir_q;
  assign in_flash   = flash_q;

endmodule

// File: tb/tb_traffic_light_multi.sv
// Scoreboard bench for traffic_light_multi: stimulus pushes per-cycle expected
// outputs from hand-derived phase segments; a negedge monitor pops and compares.
module tb_traffic_light_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       flash_mode = 1'b0;
  logic [2:0] ped_req = 3'b000;
  logic [8:0] lights;
  logic [2:0] walk;
  logic [2:0] active_dir;
  logic       in_flash;

  traffic_light_multi #(
    .NUM_DIR(3), .TICK_DIV(4), .GREEN_TICKS(5), .YELLOW_TICKS(2),
    .ALLRED_TICKS(1), .PED_EXTRA(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flash_mode(flash_mode), .ped_req(ped_req),
    .lights(lights), .walk(walk), .active_dir(active_dir), .in_flash(in_flash)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] AR  = 9'b100_100_100;
  localparam logic [8:0] G0  = 9'b100_100_001;
  localparam logic [8:0] Y0  = 9'b100_100_010;
  localparam logic [8:0] G1  = 9'b100_001_100;
  localparam logic [8:0] Y1  = 9'b100_010_100;
  localparam logic [8:0] G2  = 9'b001_100_100;
  localparam logic [8:0] Y2  = 9'b010_100_100;
  localparam logic [8:0] FL1 = 9'b010_010_010;
  localparam logic [8:0] FL0 = 9'b000_000_000;

  typedef struct {
    logic [8:0] l;
    logic [2:0] w;
    logic [2:0] d;
    logic       f;
    int         seg;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   seg_id = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (lights !== e.l || walk !== e.w || active_dir !== e.d || in_flash !== e.f) begin
        errors++;
        $display("FAIL seg%0d.c%0d: got lights=%b walk=%b dir=%0d flash=%b, want lights=%b walk=%b dir=%0d flash=%b",
                 e.seg, e.cyc, lights, walk, active_dir, in_flash, e.l, e.w, e.d, e.f);
      end
    end
  end

  task automatic seg(input int n, input logic [8:0] l, input logic [2:0] w,
                     input logic [2:0] d, input logic f, input logic r,
                     input logic e_en, input logic fm, input logic [2:0] ped_first);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      rst        = r;
      en         = e_en;
      flash_mode = fm;
      ped_req    = (k == 0) ? ped_first : 3'b000;
      e.l = l; e.w = w; e.d = d; e.f = f; e.seg = seg_id; e.cyc = k;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    seg_id++;
  endtask

  initial begin
    @(posedge clk);
    #1;
    //   n   lights walk  dir  flsh rst en  fm   ped
    seg(3,  AR,  3'b000, 3'd0, 0,  0,  1,  0, 3'b000);  // held in reset
    seg(4,  AR,  3'b000, 3'd0, 0,  1,  1,  0, 3'b000);  // first tick after TICK_DIV
    seg(20, G0,  3'b000, 3'd0, 0,  1,  1,  0, 3'b010);  // ped call for dir1
    seg(8,  Y0,  3'b000, 3'd0, 0,  1,  1,  0, 3'b000);
    seg(4,  AR,  3'b000, 3'd1, 0,  1,  1,  0, 3'b000);
    seg(32, G1,  3'b010, 3'd1, 0,  1,  1,  0, 3'b000);  // extended green with walk
    seg(8,  Y1,  3'b000, 3'd1, 0,  1,  1,  0, 3'b000);
    seg(4,  AR,  3'b000, 3'd2, 0,  1,  1,  0, 3'b000);
    seg(20, G2,  3'b000, 3'd2, 0,  1,  1,  0, 3'b100);  // call during own green: held
    seg(8,  Y2,  3'b000, 3'd2, 0,  1,  1,  0, 3'b000);
    seg(3,  AR,  3'b000, 3'd0, 0,  1,  1,  0, 3'b000);  // wrap 2 -> 0
    seg(1,  AR,  3'b000, 3'd0, 0,  1,  1,  0, 3'b001);  // call on green-entry edge
    seg(32, G0,  3'b001, 3'd0, 0,  1,  1,  0, 3'b000);
    seg(8,  Y0,  3'b000, 3'd0, 0,  1,  1,  0, 3'b000);
    seg(4,  AR,  3'b000, 3'd1, 0,  1,  1,  0, 3'b000);
    seg(20, G1,  3'b000, 3'd1, 0,  1,  1,  0, 3'b000);  // dir1 latch was cleared
    seg(4,  Y1,  3'b000, 3'd1, 0,  1,  1,  0, 3'b000);
    seg(50, Y1,  3'b000, 3'd1, 0,  1,  0,  0, 3'b000);  // en low: frozen
    seg(4,  Y1,  3'b000, 3'd1, 0,  1,  1,  0, 3'b000);  // remaining yellow
    seg(4,  AR,  3'b000, 3'd2, 0,  1,  1,  0, 3'b000);
    seg(10, G2,  3'b100, 3'd2, 0,  1,  1,  0, 3'b000);  // held call served
    seg(2,  AR,  3'b000, 3'd0, 0,  0,  1,  0, 3'b000);  // async reset mid-green
    seg(4,  AR,  3'b000, 3'd0, 0,  1,  1,  0, 3'b000);
    seg(10, G0,  3'b000, 3'd0, 0,  1,  1,  0, 3'b000);
    seg(1,  G0,  3'b000, 3'd0, 0,  1,  1,  1, 3'b000);  // flash at green cycle 10
    seg(8,  Y0,  3'b000, 3'd0, 0,  1,  1,  1, 3'b000);
    seg(4,  AR,  3'b000, 3'd1, 0,  1,  1,  1, 3'b000);
    seg(4,  FL1, 3'b000, 3'd1, 1,  1,  1,  1, 3'b000);
    seg(4,  FL0, 3'b000, 3'd1, 1,  1,  1,  1, 3'b000);
    seg(4,  FL1, 3'b000, 3'd1, 1,  1,  1,  1, 3'b000);
    seg(4,  FL0, 3'b000, 3'd1, 1,  1,  1,  0, 3'b000);  // exit at next tick
    seg(4,  AR,  3'b000, 3'd1, 0,  1,  1,  0, 3'b000);
    seg(20, G1,  3'b000, 3'd1, 0,  1,  1,  0, 3'b000);
    seg(2,  AR,  3'b000, 3'd0, 0,  0,  1,  1, 3'b000);  // reset with flash requested
    seg(4,  AR,  3'b000, 3'd0, 0,  1,  1,  1, 3'b000);
    seg(4,  FL1, 3'b000, 3'd0, 1,  1,  1,  0, 3'b000);
    seg(4,  AR,  3'b000, 3'd0, 0,  1,  1,  0, 3'b000);
    seg(5,  G0,  3'b000, 3'd0, 0,  1,  1,  0, 3'b000);  // dir unchanged after flash
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: got no completion by 20000, want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
